// File: rtl/pay_cash_ctrl_if.sv
// Cash-payment controller bus: checkout requests, coin pulses and display results.
// Ports: master drives start/count_in/price_in/confirm/cancel/coin_valid/coin_val;
//        slave drives state/count/fee/paid/ch4nge/refund/coin_rej/done/ok.
interface pay_cash_ctrl_if;
    logic       start;
    logic [8:0] count_in;
    logic [8:0] price_in;
    logic       confirm;
    logic       cancel;
    logic       coin_valid;
    logic [1:0] coin_val;

    logic [4:0] state;
    logic [8:0] count;
    logic [8:0] fee;
    logic [8:0] paid;
    logic [8:0] ch4nge;
    logic [8:0] refund;
    logic       coin_rej;
    logic       done;
    logic       ok;

    modport master (
        output start, count_in, price_in,
        output confirm, cancel,
        output coin_valid, coin_val,
        input  state, count, fee, paid,
        input  ch4nge, refund,
        input  coin_rej, done, ok
    );

    modport slave (
        input  start, count_in, price_in,
        input  confirm, cancel,
        input  coin_valid, coin_val,
        output state, count, fee, paid,
        output ch4nge, refund,
        output coin_rej, done, ok
    );
endinterface

// File: rtl/pay_cash_ctrl.sv
// Non-member cash checkout: fee = count*price, coin accumulation, change or refund.
// Ports: clk, rst (async active-low), bus (slave side of pay_cash_ctrl_if).
module pay_cash_ctrl #(
    parameter int unsigned SHOW_CYC = 100_000_000,
    parameter int unsigned HOLD_CYC = 200_000_000,
    parameter int unsigned TIMEOUT  = 1_000_000_000
) (
    input  logic           clk,
    input  logic           rst,
    pay_cash_ctrl_if.slave bus
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_SHOW   = 5'd1,
        S_INSERT = 5'd2,
        S_CHANGE = 5'd3,
        S_FAIL   = 5'd4
    } state_t;

    // Timer compares against "last cycle" so exits land exactly N cycles after entry.
    localparam logic [31:0] L_SHOW_LAST = 32'(SHOW_CYC - 1);
    localparam logic [31:0] L_HOLD_LAST = 32'(HOLD_CYC - 1);
    localparam logic [31:0] L_TO_LAST   = 32'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_tmr;
    logic [8:0]  r_count;
    logic [8:0]  r_fee;
    logic [8:0]  r_paid;
    logic [8:0]  r_ch4nge;
    logic [8:0]  r_refund;
    logic        r_coin_rej;
    logic        r_done;
    logic        r_ok;

    state_t      w_state_nxt;
    logic [31:0] w_tmr_nxt;
    logic        w_tmr_clr;
    logic [8:0]  w_count_nxt;
    logic [8:0]  w_fee_nxt;
    logic [8:0]  w_paid_nxt;
    logic [8:0]  w_ch4nge_nxt;
    logic [8:0]  w_refund_nxt;
    logic        w_coin_rej_nxt;
    logic        w_done_nxt;
    logic        w_ok_nxt;

    logic [17:0] w_prod;
    logic [9:0]  w_coin_amt;
    logic [9:0]  w_sum;
    logic        w_coin_fits;
    logic        w_paid_enough;
    logic        w_show_end;
    logic        w_hold_end;
    logic        w_ins_end;

    assign w_prod = {9'd0, bus.count_in} * {9'd0, bus.price_in};

    always_comb begin
        w_coin_amt = 10'd1;
        unique case (bus.coin_val)
            2'd0: w_coin_amt = 10'd1;
            2'd1: w_coin_amt = 10'd5;
            2'd2: w_coin_amt = 10'd10;
            2'd3: w_coin_amt = 10'd20;
        endcase
    end

    assign w_sum         = {1'b0, r_paid} + w_coin_amt;
    assign w_coin_fits   = (w_sum <= 10'd511);
    assign w_paid_enough = (w_sum >= {1'b0, r_fee});

    assign w_show_end = (r_tmr == L_SHOW_LAST);
    assign w_hold_end = (r_tmr == L_HOLD_LAST);
    assign w_ins_end  = (r_tmr == L_TO_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_tmr_clr      = 1'b0;
        w_count_nxt    = r_count;
        w_fee_nxt      = r_fee;
        w_paid_nxt     = r_paid;
        w_ch4nge_nxt   = r_ch4nge;
        w_refund_nxt   = r_refund;
        w_coin_rej_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_ok_nxt       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_count_nxt = bus.count_in;
                    if (w_prod > 18'd511) begin
                        w_fee_nxt    = 9'd511;
                        w_refund_nxt = 9'd0;
                        w_state_nxt  = S_FAIL;
                    end else begin
                        w_fee_nxt   = w_prod[8:0];
                        w_paid_nxt  = 9'd0;
                        w_state_nxt = S_SHOW;
                    end
                end
            end

            S_SHOW: begin
                if (bus.confirm || w_show_end) begin
                    if (r_fee == 9'd0) begin
                        w_ch4nge_nxt = 9'd0;
                        w_state_nxt  = S_CHANGE;
                    end else begin
                        w_state_nxt = S_INSERT;
                    end
                end
            end

            S_INSERT: begin
                // Cancel wins over a coin arriving in the same cycle.
                if (bus.cancel) begin
                    w_refund_nxt = r_paid;
                    w_state_nxt  = S_FAIL;
                end else if (bus.coin_valid && w_coin_fits) begin
                    w_paid_nxt = w_sum[8:0];
                    w_tmr_clr  = 1'b1;
                    if (w_paid_enough) begin
                        w_ch4nge_nxt = w_sum[8:0] - r_fee;
                        w_state_nxt  = S_CHANGE;
                    end
                end else begin
                    // A refused coin does not reload the timeout.
                    w_coin_rej_nxt = bus.coin_valid;
                    if (w_ins_end) begin
                        w_refund_nxt = r_paid;
                        w_state_nxt  = S_FAIL;
                    end
                end
            end

            S_CHANGE, S_FAIL: begin
                if (w_hold_end) begin
                    w_done_nxt   = 1'b1;
                    w_ok_nxt     = (r_state == S_CHANGE);
                    w_paid_nxt   = 9'd0;
                    w_ch4nge_nxt = 9'd0;
                    w_refund_nxt = 9'd0;
                    w_state_nxt  = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_tmr_clr = 1'b1;
        end
        w_tmr_nxt = w_tmr_clr ? 32'd0 : r_tmr + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tmr      <= 32'd0;
            r_count    <= 9'd0;
            r_fee      <= 9'd0;
            r_paid     <= 9'd0;
            r_ch4nge   <= 9'd0;
            r_refund   <= 9'd0;
            r_coin_rej <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_count    <= w_count_nxt;
            r_fee      <= w_fee_nxt;
            r_paid     <= w_paid_nxt;
            r_ch4nge   <= w_ch4nge_nxt;
            r_refund   <= w_refund_nxt;
            r_coin_rej <= w_coin_rej_nxt;
            r_done     <= w_done_nxt;
            r_ok       <= w_ok_nxt;
        end
    end

    assign bus.state    = r_state;
    assign bus.count    = r_count;
    assign bus.fee      = r_fee;
    assign bus.paid     = r_paid;
    assign bus.ch4nge   = r_ch4nge;
    assign bus.refund   = r_refund;
    assign bus.coin_rej = r_coin_rej;
    assign bus.done     = r_done;
    assign bus.ok       = r_ok;

endmodule
